eth_tx_arbiter: RTL and testbench

//  Shares the single Ethernet TX MAC interface (tx_start/tx_data_length/tx_data/tx_payload/tx_busy)

---
 rtl/eth_tx_arb_pkg.sv | 22 ++
 rtl/eth_tx_arbiter_rr_picker.sv | 35 +++
 rtl/eth_tx_arbiter.sv | 155 +++++++++++++++
 tb/tb_eth_tx_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_arb_pkg.sv
// rtl/eth_tx_arb_pkg.sv - shared state encoding and width constants for eth_tx_arbiter
package eth_tx_arb_pkg;

    localparam int BYTE_W          = 8;
    localparam int LEN_W           = 8;
    localparam int DEF_TIMEOUT_CYC = 1024;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_GRANT  = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_STREAM = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        GRANT  = ST_GRANT,
        START  = ST_START,
        STREAM = ST_STREAM,
        DONE   = ST_DONE
    } state_e;

endpackage

// File: rtl/eth_tx_arbiter_rr_picker.sv
// rtl/eth_tx_arbiter_rr_picker.sv - combinational round-robin pick: first request at/after ptr, wrapping
module rr_picker #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     winner_o,
    output logic             valid_o
);

    logic [2*N-1:0] rot2;
    logic [N-1:0]   rot;
    logic [N-1:0]   pick;
    logic [2*N-1:0] wide;
    logic           found;

    // Rotate so the pointer position sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        rot2  = {req_i, req_i} >> ptr_i;
        rot   = N'(rot2);
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                pick[k] = 1'b1;
                found   = 1'b1;
            end
        end
        wide     = {pick, pick} << ptr_i;
        winner_o = N'(wide >> N);
        valid_o  = found;
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// rtl/eth_tx_arbiter.sv - round-robin sharing of one Ethernet TX MAC among NUM_REQ packet sources
// Optional watchdog and err flag enabled by ETH_TX_ARB_TIMEOUT_EN.
module eth_tx_arbiter
    import eth_tx_arb_pkg::*;
#(
    parameter int NUM_REQ = 3
`ifdef ETH_TX_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
`endif
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [LEN_W*NUM_REQ-1:0]  req_len,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        req_rd,
    output logic [NUM_REQ-1:0]        req_done,
    output logic                      tx_start,
    output logic [LEN_W-1:0]          tx_data_length,
    output logic [BYTE_W-1:0]         tx_data,
    input  logic                      tx_payload,
    input  logic                      tx_busy,
    output logic                      busy,
    output logic                      err
);

    localparam int PTR_W = $clog2(NUM_REQ);

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [PTR_W-1:0]   gidx_q, gidx_d;
    logic [PTR_W-1:0]   rr_q, rr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;

    logic [NUM_REQ-1:0] win;
    logic               win_vld;
    logic [PTR_W-1:0]   win_idx;
    logic               timeout;

    rr_picker #(.N(NUM_REQ), .PTR_W(PTR_W)) u_picker (
        .req_i    (req),
        .ptr_i    (rr_q),
        .winner_o (win),
        .valid_o  (win_vld)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) win_idx = PTR_W'(i);
        end
    end

`ifdef ETH_TX_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_q;
    logic            err_q;

    // wd_q reads 1 in the first STREAM cycle, so the abort lands TIMEOUT_CYC cycles after START.
    assign timeout = (state_q == STREAM) && !tx_payload && (wd_q == WD_W'(TIMEOUT_CYC - 1));
    assign err     = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == START) begin
                wd_q <= WD_W'(1);
            end else if (state_q == STREAM) begin
                wd_q <= tx_payload ? '0 : wd_q + 1'b1;
            end
            if (timeout) err_q <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            gidx_q  <= '0;
            rr_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            rr_q    <= rr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gidx_d   = gidx_q;
        rr_d     = rr_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        req_rd   = '0;
        req_done = '0;
        tx_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    gnt_d   = win;
                    gidx_d  = win_idx;
                    len_d   = req_len[int'(win_idx)*LEN_W +: LEN_W];
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!tx_busy) state_d = (len_q == '0) ? DONE : START;
            end
            START: begin
                tx_start = 1'b1;
                state_d  = STREAM;
            end
            STREAM: begin
                if (timeout) begin
                    state_d = DONE;
                end else if (tx_payload && (cnt_q != len_q)) begin
                    req_rd = gnt_q;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q + 1'b1 == len_q) state_d = DONE;
                end
            end
            DONE: begin
                req_done = gnt_q;
                gnt_d    = '0;
                cnt_d    = '0;
                rr_d     = (gidx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt            = gnt_q;
    assign busy           = (state_q != IDLE);
    assign tx_data_length = (state_q == START || state_q == STREAM || state_q == DONE) ? len_q : '0;
    assign tx_data        = (|gnt_q) ? req_data[int'(gidx_q)*BYTE_W +: BYTE_W] : '0;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb/tb_eth_tx_arbiter.sv - scoreboard bench for eth_tx_arbiter with MAC and source models
module tb_eth_tx_arbiter;

    localparam int N = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_len;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   gnt, req_rd, req_done;
    logic           tx_start;
    logic [7:0]     tx_data_length, tx_data;
    logic           tx_payload, tx_busy;
    logic           busy, err;

    always #5 clk = ~clk;

    eth_tx_arbiter #(
        .NUM_REQ(N)
`ifdef ETH_TX_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(16)
`endif
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .req_len        (req_len),
        .req_data       (req_data),
        .gnt            (gnt),
        .req_rd         (req_rd),
        .req_done       (req_done),
        .tx_start       (tx_start),
        .tx_data_length (tx_data_length),
        .tx_data        (tx_data),
        .tx_payload     (tx_payload),
        .tx_busy        (tx_busy),
        .busy           (busy),
        .err            (err)
    );

    typedef struct {
        int src;
        int len;
        int exp_cnt;
        bit exp_start;
    } pkt_t;

    pkt_t     exp_q[$];
    int       vectors = 0;
    int       miscompares = 0;
    int       cyc = 0;
    int       pkts[N];
    int       idx[N];
    int       lens[N];
    bit       mac_en = 1'b1;
    int       mac_rem = 0;
    int       cur_cnt = 0;
    bit       cur_start = 1'b0;
    int       start_cyc = -1, gnt_cyc = -1, err_cyc = -1, last_rd_cyc = -1;
    int       total_done = 0;
    logic [N-1:0] prev_gnt = '0;

    function automatic logic [N-1:0] oh(int s);
        return N'(1) << s;
    endfunction

    task automatic drive_srcs();
        for (int i = 0; i < N; i++) begin
            req[i]            = (pkts[i] > 0);
            req_len[i*8 +: 8] = 8'(lens[i]);
            req_data[i*8 +: 8] = 8'(i*64 + idx[i]);
        end
    endtask

    // One clock: MAC drives tx_payload, outputs are checked mid-cycle, sources advance after the edge.
    task automatic step();
        logic [N-1:0] rd_s, done_s;
        pkt_t p;
        @(negedge clk);
        tx_payload = mac_en && (mac_rem > 0);
        #1;
        rd_s   = req_rd;
        done_s = req_done;
        if (tx_payload) mac_rem--;
        if ((|gnt) && (prev_gnt == '0)) gnt_cyc = cyc;
        prev_gnt = gnt;
        if (err === 1'b1 && err_cyc < 0) err_cyc = cyc;
        if (tx_start === 1'b1) begin
            start_cyc = cyc;
            cur_start = 1'b1;
            mac_rem   = int'(tx_data_length);
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL start_unexpected: gnt=%b len=%0d", gnt, tx_data_length);
            end else if (gnt !== oh(exp_q[0].src) || tx_data_length !== 8'(exp_q[0].len)) begin
                miscompares++;
                $display("FAIL start: gnt=%b len=%0d required gnt=%b len=%0d",
                         gnt, tx_data_length, oh(exp_q[0].src), exp_q[0].len);
            end
        end
        if (|rd_s) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL rd_unexpected: req_rd=%b", rd_s);
            end else if (rd_s !== oh(exp_q[0].src) ||
                         tx_data !== 8'(exp_q[0].src*64 + idx[exp_q[0].src])) begin
                miscompares++;
                $display("FAIL rd_byte: req_rd=%b tx_data=%h required req_rd=%b tx_data=%h",
                         rd_s, tx_data, oh(exp_q[0].src), 8'(exp_q[0].src*64 + idx[exp_q[0].src]));
            end
            cur_cnt++;
            last_rd_cyc = cyc;
        end
        if (|done_s) begin
            vectors++;
            total_done++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL done_unexpected: req_done=%b", done_s);
            end else begin
                p = exp_q.pop_front();
                if (done_s !== oh(p.src) || cur_cnt != p.exp_cnt || cur_start != p.exp_start ||
                    (p.exp_cnt > 0 && cyc != last_rd_cyc + 1)) begin
                    miscompares++;
                    $display("FAIL done: req_done=%b bytes=%0d started=%0d gap=%0d required req_done=%b bytes=%0d started=%0d gap=1",
                             done_s, cur_cnt, cur_start, cyc - last_rd_cyc, oh(p.src), p.exp_cnt, p.exp_start);
                end
            end
            cur_cnt   = 0;
            cur_start = 1'b0;
            mac_rem   = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (rd_s[i]) idx[i]++;
            if (done_s[i] && pkts[i] > 0) pkts[i]--;
        end
        drive_srcs();
    endtask

    task automatic run_idle(int budget);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || busy) && n < budget) begin
            step();
            n++;
        end
        vectors++;
        if (n >= budget) begin
            miscompares++;
            $display("FAIL run_timeout: %0d packets still pending after %0d cycles, required 0", exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic check_idle_outputs(string name);
        vectors++;
        if ({gnt, req_rd, req_done, tx_start, tx_data_length, tx_data, busy, err} !== '0) begin
            miscompares++;
            $display("FAIL %s: gnt=%b rd=%b done=%b start=%b len=%0d data=%h busy=%b err=%b required all 0",
                     name, gnt, req_rd, req_done, tx_start, tx_data_length, tx_data, busy, err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        check_idle_outputs("reset_state");
        reset = 1'b0;
    endtask

    task automatic test_single();
        int rq;
        lens[1] = 24;
        pkts[1] = 1;
        exp_q.push_back('{1, 24, 24, 1'b1});
        drive_srcs();
        rq = cyc;
        step();
        step();
        lens[1] = 99;
        drive_srcs();
        run_idle(200);
        vectors++;
        if (gnt_cyc != rq + 1 || start_cyc != rq + 2) begin
            miscompares++;
            $display("FAIL single_latency: gnt at +%0d start at +%0d required +1 +2", gnt_cyc - rq, start_cyc - rq);
        end
        vectors++;
        if (gnt !== '0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_release: gnt=%b busy=%b required 000 0", gnt, busy);
        end
    endtask

    task automatic test_len_zero();
        lens[2] = 0;
        pkts[2] = 1;
        exp_q.push_back('{2, 0, 0, 1'b0});
        drive_srcs();
        run_idle(50);
    endtask

    task automatic test_round_robin();
        lens[0] = 24;
        lens[1] = 34;
        lens[2] = 24;
        pkts[0] = 2;
        pkts[1] = 1;
        pkts[2] = 1;
        exp_q.push_back('{0, 24, 24, 1'b1});
        exp_q.push_back('{1, 34, 34, 1'b1});
        exp_q.push_back('{2, 24, 24, 1'b1});
        exp_q.push_back('{0, 24, 24, 1'b1});
        drive_srcs();
        run_idle(600);
    endtask

    task automatic test_busy_hold();
        int b;
        tx_busy = 1'b1;
        lens[0] = 8;
        pkts[0] = 1;
        exp_q.push_back('{0, 8, 8, 1'b1});
        drive_srcs();
        for (int i = 0; i < 11; i++) step();
        vectors++;
        if (gnt !== 3'b001 || cur_start != 1'b0) begin
            miscompares++;
            $display("FAIL busy_hold: gnt=%b started=%0d required gnt=001 started=0", gnt, cur_start);
        end
        tx_busy = 1'b0;
        b = cyc;
        run_idle(100);
        vectors++;
        if (start_cyc != b + 1) begin
            miscompares++;
            $display("FAIL busy_release: start at +%0d required +1", start_cyc - b);
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        lens[2] = 24;
        pkts[2] = 1;
        exp_q.push_back('{2, 24, 24, 1'b1});
        drive_srcs();
        for (int i = 0; i < 200 && cur_cnt < 5; i++) step();
        d0 = total_done;
        reset = 1'b1;
        step();
        exp_q.delete();
        cur_cnt   = 0;
        cur_start = 1'b0;
        mac_rem   = 0;
        pkts[2]   = 0;
        drive_srcs();
        check_idle_outputs("reset_mid");
        vectors++;
        if (total_done != d0) begin
            miscompares++;
            $display("FAIL reset_mid_done: %0d req_done pulses, required 0", total_done - d0);
        end
        reset = 1'b0;
        lens[1] = 5;
        pkts[1] = 1;
        exp_q.push_back('{1, 5, 5, 1'b1});
        drive_srcs();
        run_idle(100);
    endtask

`ifdef ETH_TX_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int d0;
        int s0;
        mac_en  = 1'b0;
        err_cyc = -1;
        lens[0] = 8;
        lens[1] = 8;
        pkts[0] = 1;
        pkts[1] = 1;
        exp_q.push_back('{0, 8, 0, 1'b1});
        exp_q.push_back('{1, 8, 8, 1'b1});
        drive_srcs();
        d0 = total_done;
        for (int i = 0; i < 100 && total_done == d0; i++) step();
        s0 = start_cyc;
        vectors++;
        if (err_cyc != s0 + 16) begin
            miscompares++;
            $display("FAIL timeout_err: err at start+%0d required start+16", err_cyc - s0);
        end
        mac_en = 1'b1;
        run_idle(100);
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_sticky: err=%b required 1", err);
        end
    endtask
`endif

    initial begin
        reset      = 1'b1;
        tx_busy    = 1'b0;
        tx_payload = 1'b0;
        for (int i = 0; i < N; i++) begin
            pkts[i] = 0;
            idx[i]  = 0;
            lens[i] = 0;
        end
        drive_srcs();
        test_reset();
        test_single();
        test_len_zero();
        test_round_robin();
        test_busy_hold();
        test_reset_mid();
`ifdef ETH_TX_ARB_TIMEOUT_EN
        test_timeout();
`else
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_tied: err=%b required 0", err);
        end
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
